// File: rtl/seq_div_control.sv
// seq_div_control
// Sequential restoring divider with its own control FSM. One quotient bit is
// produced per clock; WIDTH iterations follow the accepting edge, and done
// pulses for one cycle afterwards.
//
// Optional build macro: SEQ_DIV_SIGNED_EN
//   When this macro is defined, the operands are treated as two's complement.
//   The core runs on magnitudes, and the signs are applied on the final
//   iteration, so division truncates toward zero.
//
// Ports:
//   clk          rising-edge clock
//   reset_a      asynchronous active-low reset
//   start        request a new division (sampled on rising edge)
//   dividend     numerator, sampled when start is accepted
//   divisor      denominator, sampled when start is accepted
//   quotient     registered result, held until the next completion
//   remainder    registered result, held until the next completion
//   done         one-cycle completion strobe (state CALC_DONE)
//   busy         high while the divider iterates (state CALC)
//   div_by_zero  sticky: the last accepted start had divisor == 0
//   abort        sticky: start was asserted during CALC
//   state_out    current state encoding
module seq_div_control #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             abort,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CALC      = 3'b001,
    CALC_DONE = 3'b100,
    ERR       = 3'b101
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  // One restoring step. The trial value is WIDTH+1 bits wide, so the top bit
  // shifted out of r_work is never lost before the comparison is made.
  always_comb begin
    trial = {r_work, q_work[WIDTH-1]};
    diff  = trial - {1'b0, dvsr};
    if (trial >= {1'b0, dvsr}) begin
      q_bit  = 1'b1;
      r_next = diff[WIDTH-1:0];
    end else begin
      q_bit  = 1'b0;
      r_next = trial[WIDTH-1:0];
    end
    q_next = {q_work[WIDTH-2:0], q_bit};
  end

`ifdef SEQ_DIV_SIGNED_EN
  // The core runs on magnitudes. The most-negative value maps onto itself,
  // which reads as 2**(WIDTH-1) when it is treated as unsigned.
  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
    q_final      = neg_q ? ('0 - q_next) : q_next;
    r_final      = neg_r ? ('0 - r_next) : r_next;
  end
`else
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    q_final      = q_next;
    r_final      = r_next;
  end
`endif

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state       <= IDLE;
      q_work      <= '0;
      r_work      <= '0;
      dvsr        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      abort       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, CALC_DONE, ERR: begin
          if (start) begin
            abort <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              state       <= ERR;
            end else begin
              div_by_zero <= 1'b0;
              dvsr        <= divisor_mag;
              q_work      <= dividend_mag;
              r_work      <= '0;
              count       <= '0;
`ifdef SEQ_DIV_SIGNED_EN
              neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r       <= dividend[WIDTH-1];
`endif
              state       <= CALC;
            end
          end else if (state != ERR) begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (start) begin
            abort <= 1'b1;
            state <= ERR;
          end else begin
            q_work <= q_next;
            r_work <= r_next;
            count  <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              quotient  <= q_final;
              remainder <= r_final;
              state     <= CALC_DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done      = (state == CALC_DONE);
  assign busy      = (state == CALC);
  assign state_out = state;

endmodule

// File: tb/tb_seq_div_control.sv
module tb_seq_div_control;

  logic       clk;
  logic       reset_a;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       busy;
  logic       div_by_zero;
  logic       abort;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div_control #(.WIDTH(8), .CW(4)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .abort       (abort),
    .state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge where start is applied; returns at the negedge after E0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after E0. The count n reaches 9 when done is seen
  // after E8. The loop is bounded so that a stuck DUT fails instead of hanging.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  int  cyc;
  int  nbusy;
  logic seen_done;

  initial begin
`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{8'h9C, 8'd7,   8'hF2, 8'hFE}); // -100/7
    vecs.push_back('{8'd100, 8'hF9, 8'hF2, 8'd2});  // 100/-7
    vecs.push_back('{8'h80, 8'hFF,  8'h80, 8'd0});  // -128/-1
    vecs.push_back('{8'hF9, 8'd2,   8'hFD, 8'hFF}); // -7/2
    vecs.push_back('{8'd100, 8'd10, 8'd10, 8'd0});
    vecs.push_back('{8'd5,  8'd9,   8'd0,  8'd5});
`else
    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5});
    vecs.push_back('{8'd42,  8'd6,   8'd7,   8'd0});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254});
    vecs.push_back('{8'd128, 8'd3,   8'd42,  8'd2});
    vecs.push_back('{8'd255, 8'd16,  8'd15,  8'd15});
`endif

    reset_a  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_flags", {28'd0, done, busy, div_by_zero, abort}, 0);
    check("rst_state", 32'(state_out), 0);
    reset_a = 1'b1;
    @(negedge clk);

    // First operation, with a trace of the state sequence
    start_op(8'd100, 8'd7);
    check("seq_state_calc", 32'(state_out), 32'b001);
    wait_done(cyc, nbusy);
    check("seq_latency", cyc, 9);
    check("seq_busy_cycles", nbusy, 8);
    check("seq_state_done", 32'(state_out), 32'b100);
    check("seq_q", 32'(quotient), 14);
    check("seq_r", 32'(remainder), 2);
    @(negedge clk);
    check("seq_done_one_cycle", 32'(done), 0);
    check("seq_state_idle", 32'(state_out), 32'b000);
    @(negedge clk);
    check("seq_hold_q", 32'(quotient), 14);
    check("seq_stay_idle", 32'(state_out), 32'b000);

    // Table-driven operations
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(cyc, nbusy);
      check($sformatf("vec%0d_latency", i), cyc, 9);
      check($sformatf("vec%0d_q", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), {30'd0, div_by_zero, abort}, 0);
      @(negedge clk);
    end

    // Establish a known result before the corner cases
    start_op(8'd100, 8'd7);
    wait_done(cyc, nbusy);
    @(negedge clk);

    // Divide by zero
    start_op(8'd42, 8'd0);
    check("dbz_state", 32'(state_out), 32'b101);
    check("dbz_flag", 32'(div_by_zero), 1);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen_done |= done;
      @(negedge clk);
    end
    check("dbz_no_done", 32'(seen_done), 0);
    check("dbz_stays_err", 32'(state_out), 32'b101);
    check("dbz_q_kept", 32'(quotient), 14);
    check("dbz_r_kept", 32'(remainder), 2);
    start_op(8'd42, 8'd6);
    wait_done(cyc, nbusy);
    check("dbz_recover_q", 32'(quotient), 7);
    check("dbz_recover_r", 32'(remainder), 0);
    check("dbz_cleared", 32'(div_by_zero), 0);
    @(negedge clk);

    // Abort: start pulsed again three cycles into CALC
    start_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    start_op(8'd0, 8'd0);
    check("abort_flag", 32'(abort), 1);
    check("abort_state", 32'(state_out), 32'b101);
    check("abort_q_kept", 32'(quotient), 7);
    check("abort_r_kept", 32'(remainder), 0);
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done), 0);
    start_op(8'd100, 8'd10);
    wait_done(cyc, nbusy);
    check("abort_recover_lat", cyc, 9);
    check("abort_recover_q", 32'(quotient), 10);
    check("abort_recover_r", 32'(remainder), 0);
    check("abort_cleared", 32'(abort), 0);
    @(negedge clk);

    // Back-to-back: start held high across CALC_DONE
    start_op(8'd100, 8'd7);
    wait_done(cyc, nbusy);
    check("b2b_first_q", 32'(quotient), 14);
    start_op(8'd100, 8'd10);
    check("b2b_no_idle", 32'(state_out), 32'b001);
    wait_done(cyc, nbusy);
    check("b2b_latency", cyc, 9);
    check("b2b_second_q", 32'(quotient), 10);
    @(negedge clk);

    // Asynchronous reset during CALC
    start_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    check("arst_q", 32'(quotient), 0);
    check("arst_r", 32'(remainder), 0);
    check("arst_flags", {28'd0, done, busy, div_by_zero, abort}, 0);
    check("arst_state", 32'(state_out), 0);
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    start_op(8'd100, 8'd7);
    wait_done(cyc, nbusy);
    check("arst_recover_lat", cyc, 9);
    check("arst_recover_q", 32'(quotient), 14);
    check("arst_recover_r", 32'(remainder), 2);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div_control.md
Name: seq_div_control

Overview:
- Sequential restoring divider with its own control FSM: unsigned WIDTH-bit dividend / WIDTH-bit divisor -> quotient + remainder.
- Computes one quotient bit per clock.
- Inverse datapath companion to the team's sequential 8x8 multiplier; uses the same start/done/state_out control style and error-state recovery.
- Sits beside the multiplier in the arithmetic unit.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CW, 4, iteration counter width; must satisfy 2**CW > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_a  input  1  asynchronous, active-low reset.
- start  input  1  request a new division; sampled on rising edge.
- dividend  input  WIDTH  numerator; sampled when start is accepted.
- divisor  input  WIDTH  denominator; sampled when start is accepted.
- quotient  output  WIDTH  registered result, held until next completion.
- remainder  output  WIDTH  registered result, held until next completion.
- done  output  1  one-cycle completion strobe (Moore, state CALC_DONE).
- busy  output  1  high while state is CALC.
- div_by_zero  output  1  sticky flag: last accepted start had divisor==0.
- abort  output  1  sticky flag: start asserted during CALC.
- state_out  output  3  current state encoding.

Behaviour:
- States and encodings:
  - IDLE = 3'b000
  - CALC = 3'b001
  - CALC_DONE = 3'b100
  - ERR = 3'b101
- Reset (reset_a=0, asynchronous):
  - state = IDLE.
  - quotient, remainder, count and working registers = 0.
  - div_by_zero = 0, abort = 0.
  - Therefore done = 0, busy = 0, state_out = 000.
  - Reset mid-operation discards the computation immediately; results read 0.
- Accepting start (state IDLE, CALC_DONE or ERR, start=1):
  - Clear div_by_zero and abort.
  - If divisor==0: set div_by_zero and go to ERR; quotient/remainder unchanged.
  - Otherwise: latch the divisor, set q_work = dividend, r_work = 0, count = 0, and go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC, start=0, each cycle:
  - trial = {r_work[WIDTH-1:0], q_work[WIDTH-1]} (WIDTH+1 bits).
  - If trial >= divisor: r_work = trial - divisor, new quotient bit = 1.
  - Else: r_work = trial[WIDTH-1:0], new quotient bit = 0.
  - q_work = {q_work[WIDTH-2:0], new quotient bit}.
  - count increments.
  - When count == WIDTH-1 (final iteration): load quotient/remainder from the final values and go to CALC_DONE.
- CALC, start=1:
  - Set abort and go to ERR; no iteration that cycle.
  - quotient/remainder keep their previous values.
- CALC_DONE:
  - done = 1 for exactly this one cycle.
  - start=0: go to IDLE. start=1: treated as a new accepted start.
- ERR: stay in ERR until start=1 (accepted start as above). done = 0.
- Latency: the edge accepting start is E0. Iterations occur on E1..E_WIDTH. quotient/remainder become valid at E_WIDTH, and done is high in the cycle following E_WIDTH. For WIDTH=8: 9 cycles from start to done.
- Back-to-back: start held high across CALC_DONE restarts with no IDLE cycle; throughput is one result per WIDTH+1 cycles.
- Arithmetic:
  - All comparisons are unsigned, with a WIDTH+1-bit trial value; no truncation loss.
  - Remainder < divisor always.
  - dividend < divisor gives quotient 0, remainder = dividend.
- Unused/default state encodings go to IDLE on the next edge.

Optional Feature:
- Macro SEQ_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - On accept, the absolute values of dividend and divisor are latched, and their signs are stored.
  - The unsigned core runs unchanged.
  - On the final iteration the quotient is negated if the signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1 returns quotient = most-negative (wraps) with remainder 0; no flag is raised.
  - Latency unchanged.
- Not defined: pure unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- Reset, then start=1 with dividend=200, divisor=7 (WIDTH=8) -> busy for 8 cycles; done pulses 9 cycles after start; quotient=28, remainder=4; state_out 000->001->100->000.
- dividend=255, divisor=1, then dividend=5, divisor=9 -> 255 r 0, then 0 r 5; outputs hold between operations.
- divisor=0 with dividend=42 -> state ERR (101), div_by_zero=1, done never asserts; a following start with 42/6 -> quotient 7, remainder 0, div_by_zero cleared.
- start pulsed again 3 cycles into CALC -> abort=1, state ERR, quotient/remainder keep their prior values; a new start with 100/10 -> quotient 10, remainder 0.
- reset_a asserted during CALC -> all outputs 0 immediately (asynchronous), state IDLE; start after release computes normally.
- SEQ_DIV_SIGNED_EN: -100/7 -> quotient -14, remainder -2; 100/-7 -> quotient -14, remainder 2; -128/-1 -> quotient -128, remainder 0.
